// File: rtl/cfg_pkg.sv
// cfg_pkg: shared constants, state encoding and command packing for the configuration byte stream
package cfg_pkg;
    localparam logic [1:0] CFG_X  = 2'd0;
    localparam logic [1:0] CFG_Y  = 2'd1;
    localparam logic [1:0] CFG_AB = 2'd2;
    localparam logic [1:0] CFG_CX = 2'd3;
    localparam logic [7:0] CMD_MASK  = 8'h7F;
    localparam logic [7:0] IDLE_BYTE = 8'h00;
    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_DATA, ST_CLR_CMD, ST_CLR_DATA} state_t;
    function automatic logic [7:0] pack_cmd(input logic [1:0] layer, input logic [2:0] bits, input logic [1:0] cfg);
        return {1'b1, layer, bits, cfg};
    endfunction
endpackage

// File: rtl/cfg_stream_tx_if.sv
// cfg_stream_tx_if: valid/ready entry interface feeding the configuration transmitter
interface cfg_stream_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_is_mask;
    logic [1:0] in_layer;
    logic [2:0] in_bits;
    logic [1:0] in_cfg;
    logic [7:0] in_data;
    modport master(output in_valid, in_is_mask, in_layer, in_bits, in_cfg, in_data, input in_ready);
    modport slave(input in_valid, in_is_mask, in_layer, in_bits, in_cfg, in_data, output in_ready);
endinterface

// File: rtl/cfg_clear_ctr.sv
// cfg_clear_ctr: 7-bit clear-sequence entry counter split into layer/bits/cfg fields
module cfg_clear_ctr (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [1:0] layer,
    output logic [2:0] bits,
    output logic [1:0] cfg,
    output logic       tc
);
    logic [6:0] cnt;
    always_ff @(posedge clk) cnt <= clr ? 7'd0 : cnt + 7'(en);
    assign {layer, bits, cfg} = cnt;
    assign tc = &cnt;
endmodule

// File: rtl/cfg_stream_tx.sv
// cfg_stream_tx: serialises configuration entries and the self-timed clear sequence onto cfg_out
module cfg_stream_tx
    import cfg_pkg::*;
#(
    parameter logic [7:0] CLR_DATA = 8'h00,
    parameter logic [7:0] CLR_MASK = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_start,
    cfg_stream_tx_if.slave   up,
    output logic             busy,
    output logic             done,
    output logic [7:0]       cfg_out
);
    state_t     state, nxt;
    logic [7:0] cmd_q, data_q, cmd_d, data_d, byte_d;
    logic       mask_ph, mask_d, fin, fin_d, done_d;
    logic       take, ctr_en, ctr_clr, tc;
    logic [1:0] c_layer, c_cfg;
    logic [2:0] c_bits;

    cfg_clear_ctr u_ctr (
        .clk  (clk),
        .clr  (!rst_n || ctr_clr),
        .en   (ctr_en),
        .layer(c_layer),
        .bits (c_bits),
        .cfg  (c_cfg),
        .tc   (tc)
    );

    assign up.in_ready = rst_n && (state == ST_IDLE || state == ST_DATA) && !clear_start;
    assign take = up.in_valid && up.in_ready;
    assign busy = state != ST_IDLE;

    // mask_ph: entry 127 has been commanded, next command is the mask; fin: mask data is on the bus
    always_comb begin
        nxt     = state;
        cmd_d   = cmd_q;
        data_d  = data_q;
        mask_d  = mask_ph;
        fin_d   = fin;
        ctr_en  = 1'b0;
        ctr_clr = 1'b0;
        unique case (state)
            ST_IDLE:     nxt = clear_start ? ST_CLR_CMD : take ? ST_CMD : ST_IDLE;
            ST_CMD:      nxt = ST_DATA;
            ST_DATA:     nxt = take ? ST_CMD : ST_IDLE;
            ST_CLR_CMD: begin
                nxt    = ST_CLR_DATA;
                ctr_en = !mask_ph;
                mask_d = mask_ph || tc;
                fin_d  = mask_ph;
            end
            ST_CLR_DATA: begin
                nxt     = fin ? ST_IDLE : ST_CLR_CMD;
                ctr_clr = fin;
                mask_d  = mask_ph && !fin;
                fin_d   = 1'b0;
            end
            default:     nxt = ST_IDLE;
        endcase
        if (take && !clear_start) begin
            cmd_d  = up.in_is_mask ? CMD_MASK : pack_cmd(up.in_layer, up.in_bits, up.in_cfg);
            data_d = up.in_data;
        end
        byte_d = nxt == ST_CMD      ? cmd_d :
                 nxt == ST_DATA     ? data_q :
                 nxt == ST_CLR_CMD  ? (mask_ph ? CMD_MASK : pack_cmd(c_layer, c_bits, c_cfg)) :
                 nxt == ST_CLR_DATA ? (mask_ph ? CLR_MASK : CLR_DATA) : IDLE_BYTE;
        done_d = state == ST_CLR_DATA && fin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cfg_out <= IDLE_BYTE;
            done    <= 1'b0;
            mask_ph <= 1'b0;
            fin     <= 1'b0;
            cmd_q   <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state   <= nxt;
            cfg_out <= byte_d;
            done    <= done_d;
            mask_ph <= mask_d;
            fin     <= fin_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
        end
    end
endmodule
